// File: rtl/periph_arb_pkg.sv
// Shared types and sizing helpers for the peripheral bus arbiter.
package periph_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   // Watchdog counter width; it must hold TIMEOUT_CYCLES-1.
   function automatic int timer_width(input int cycles);
      return (cycles > 2) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/periph_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first active request at or after the pointer.
module rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [IDX_W-1:0]   grant_o,
   output logic               valid_o
);

   logic [IDX_W-1:0] cand [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand[gi] = IDX_W'((int'(ptr_i) + gi) % NUM_REQ);
   end

   // Scan from the farthest offset down so the nearest requester wins.
   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_i[cand[k]]) begin
            grant_o = cand[k];
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral port between NUM_REQ masters,
// with a watchdog that turns a silent peripheral into an error response.
module periph_bus_arbiter
   import periph_arb_pkg::*;
#(
   parameter int          NUM_REQ        = 2,
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ*32-1:0] req_addr,
   input  logic [NUM_REQ*4-1:0]  req_rmask,
   input  logic [NUM_REQ*4-1:0]  req_wmask,
   input  logic [NUM_REQ*32-1:0] req_wdata,
   output logic [31:0]           req_rdata,
   output logic [NUM_REQ-1:0]    req_resp,
   output logic                  req_err,
   output logic [31:0]           mem_addr,
   output logic [3:0]            mem_rmask,
   output logic [3:0]            mem_wmask,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_resp
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int TW    = timer_width(TIMEOUT_CYCLES);

   arb_state_e         state_q;
   logic [IDX_W-1:0]   grant_q;
   logic [IDX_W-1:0]   rr_q;
   logic [IDX_W-1:0]   rr_d;
   logic [TW-1:0]      timer_q;
   logic [TW-1:0]      timer_d;
   logic [31:0]        mem_addr_q;
   logic [3:0]         mem_rmask_q;
   logic [3:0]         mem_wmask_q;
   logic [31:0]        mem_wdata_q;
   logic [31:0]        req_rdata_q;
   logic [NUM_REQ-1:0] req_resp_q;
   logic               req_err_q;

   logic [NUM_REQ-1:0] req_vec;
   logic [NUM_REQ-1:0] grant_oh;
   logic [31:0]        addr_arr  [NUM_REQ];
   logic [31:0]        wdata_arr [NUM_REQ];
   logic [3:0]         rmask_arr [NUM_REQ];
   logic [3:0]         wmask_arr [NUM_REQ];
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*32 +: 32];
      assign wdata_arr[gi] = req_wdata[gi*32 +: 32];
      assign rmask_arr[gi] = req_rmask[gi*4 +: 4];
      assign wmask_arr[gi] = req_wmask[gi*4 +: 4];
      assign req_vec[gi]   = |{req_rmask[gi*4 +: 4], req_wmask[gi*4 +: 4]};
      assign grant_oh[gi]  = (grant_q == IDX_W'(gi));
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_i   (req_vec),
      .ptr_i   (rr_q),
      .grant_o (pick_idx),
      .valid_o (pick_valid)
   );

   assign rr_d    = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
   assign timer_d = timer_q + TW'(1);

   // mem_addr/mem_wdata double as the transaction latches; only the masks pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_q        <= '0;
         timer_q     <= '0;
         mem_addr_q  <= '0;
         mem_rmask_q <= '0;
         mem_wmask_q <= '0;
         mem_wdata_q <= '0;
         req_rdata_q <= '0;
         req_resp_q  <= '0;
         req_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  grant_q     <= pick_idx;
                  mem_addr_q  <= addr_arr[pick_idx];
                  mem_wdata_q <= wdata_arr[pick_idx];
                  mem_rmask_q <= rmask_arr[pick_idx];
                  mem_wmask_q <= wmask_arr[pick_idx];
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               mem_rmask_q <= '0;
               mem_wmask_q <= '0;
               timer_q     <= '0;
               state_q     <= WAIT;
            end
            WAIT: begin
               if (mem_resp) begin
                  req_rdata_q <= mem_rdata;
                  req_err_q   <= 1'b0;
                  req_resp_q  <= grant_oh;
                  state_q     <= RESP;
               end else if (timer_d == TW'(TIMEOUT_CYCLES - 1)) begin
                  req_rdata_q <= ERR_RDATA;
                  req_err_q   <= 1'b1;
                  req_resp_q  <= grant_oh;
                  state_q     <= RESP;
               end else begin
                  timer_q <= timer_d;
               end
            end
            RESP: begin
               req_rdata_q <= '0;
               req_resp_q  <= '0;
               req_err_q   <= 1'b0;
               rr_q        <= rr_d;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_rmask = mem_rmask_q;
   assign mem_wmask = mem_wmask_q;
   assign mem_wdata = mem_wdata_q;
   assign req_rdata = req_rdata_q;
   assign req_resp  = req_resp_q;
   assign req_err   = req_err_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter: read, contention, timeout, drop, reset, spurious resp.
module tb_periph_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] req_addr;
   logic [7:0]  req_rmask;
   logic [7:0]  req_wmask;
   logic [63:0] req_wdata;
   logic [31:0] req_rdata;
   logic [1:0]  req_resp;
   logic        req_err;
   logic [31:0] mem_addr;
   logic [3:0]  mem_rmask;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;

   int n_checks = 0;
   int n_fail   = 0;
   int pulse_cnt = 0;
   int resp_cnt  = 0;

   periph_bus_arbiter #(
      .NUM_REQ        (2),
      .TIMEOUT_CYCLES (16),
      .ERR_RDATA      (32'hDEAD_BEEF)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_addr  (req_addr),
      .req_rmask (req_rmask),
      .req_wmask (req_wmask),
      .req_wdata (req_wdata),
      .req_rdata (req_rdata),
      .req_resp  (req_resp),
      .req_err   (req_err),
      .mem_addr  (mem_addr),
      .mem_rmask (mem_rmask),
      .mem_wmask (mem_wmask),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_resp  (mem_resp)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if ((mem_rmask | mem_wmask) != 4'h0) pulse_cnt++;
      if (req_resp != 2'b00) resp_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic set_req(input int m, input logic [31:0] a, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] wd);
      req_addr[m*32 +: 32]  = a;
      req_rmask[m*4 +: 4]   = rm;
      req_wmask[m*4 +: 4]   = wm;
      req_wdata[m*32 +: 32] = wd;
   endtask

   task automatic clear_reqs();
      req_addr  = '0;
      req_rmask = '0;
      req_wmask = '0;
      req_wdata = '0;
   endtask

   // Called at the negedge of the IDLE cycle in which the request is sampled.
   // lat < 0 means the peripheral never answers.
   task automatic txn(input string tag, input int g, input logic [31:0] ea,
                      input logic [3:0] erm, input logic [3:0] ewm, input logic [31:0] ewd,
                      input int lat, input logic [31:0] prd, input logic [31:0] erd,
                      input logic eerr, input int elat, input bit drop);
      int k;
      bit got;
      cyc();
      check_val({tag, "_maddr"}, mem_addr, ea);
      check_val({tag, "_mrmask"}, {28'b0, mem_rmask}, {28'b0, erm});
      check_val({tag, "_mwmask"}, {28'b0, mem_wmask}, {28'b0, ewm});
      check_val({tag, "_mwdata"}, mem_wdata, ewd);
      if (drop) set_req(g, 32'hFFFF_0000, 4'h0, 4'h0, 32'h0BAD_0BAD);
      cyc();
      check_val({tag, "_mask_off"}, {24'b0, mem_rmask, mem_wmask}, 32'h0);
      check_val({tag, "_addr_hold"}, mem_addr, ea);
      k   = 1;
      got = 1'b0;
      while (!got && k < 64) begin
         if (k - 1 == lat) begin
            mem_resp  = 1'b1;
            mem_rdata = prd;
         end
         cyc();
         k++;
         mem_resp  = 1'b0;
         mem_rdata = 32'h0;
         if (req_resp != 2'b00) got = 1'b1;
      end
      check_val({tag, "_latency"}, 32'(k), 32'(elat));
      check_val({tag, "_resp"}, {30'b0, req_resp}, 32'(1) << g);
      check_val({tag, "_rdata"}, req_rdata, erd);
      check_val({tag, "_err"}, {31'b0, req_err}, {31'b0, eerr});
      cyc();
      check_val({tag, "_after"}, req_rdata | {29'b0, req_err, req_resp}, 32'h0);
   endtask

   initial begin
      int p0;
      int r0;
      rst_n     = 1'b0;
      mem_resp  = 1'b0;
      mem_rdata = 32'h0;
      clear_reqs();
      cyc();
      cyc();
      check_val("reset_mem", mem_addr | mem_wdata | {24'b0, mem_rmask, mem_wmask}, 32'h0);
      check_val("reset_req", req_rdata | {29'b0, req_err, req_resp}, 32'h0);
      rst_n = 1'b1;

      // Single read from master0.
      cyc();
      set_req(0, 32'h4, 4'hF, 4'h0, 32'h0);
      p0 = pulse_cnt;
      txn("read0", 0, 32'h4, 4'hF, 4'h0, 32'h0, 0, 32'h5A, 32'h5A, 1'b0, 2, 1'b0);
      check_val("read0_pulses", 32'(pulse_cnt - p0), 32'd1);
      clear_reqs();

      // Contention from reset: both masters held, grants alternate 0,1,0,1.
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      set_req(0, 32'h10, 4'h0, 4'hF, 32'h1111_1111);
      set_req(1, 32'h20, 4'h0, 4'h3, 32'h2222_2222);
      for (int t = 0; t < 4; t++) begin
         if (t % 2 == 0)
            txn($sformatf("cont%0d_m0", t), 0, 32'h10, 4'h0, 4'hF, 32'h1111_1111,
                0, 32'hA0 + t, 32'hA0 + t, 1'b0, 2, 1'b0);
         else
            txn($sformatf("cont%0d_m1", t), 1, 32'h20, 4'h0, 4'h3, 32'h2222_2222,
                0, 32'hA0 + t, 32'hA0 + t, 1'b0, 2, 1'b0);
      end
      clear_reqs();

      // Master0 drops its write after latching; the original write still completes once.
      set_req(0, 32'h30, 4'h0, 4'hF, 32'hCAFE_F00D);
      p0 = pulse_cnt;
      txn("drop", 0, 32'h30, 4'h0, 4'hF, 32'hCAFE_F00D, 0, 32'h0, 32'h0, 1'b0, 2, 1'b1);
      check_val("drop_pulses", 32'(pulse_cnt - p0), 32'd1);
      clear_reqs();

      // Master1 read with a silent peripheral: error after TIMEOUT_CYCLES.
      set_req(1, 32'h44, 4'hF, 4'h0, 32'h0);
      txn("timeout", 1, 32'h44, 4'hF, 4'h0, 32'h0, -1, 32'h0, 32'hDEAD_BEEF, 1'b1, 16, 1'b0);
      clear_reqs();

      // Advance pointer to 1, then reset master1's transaction during WAIT.
      set_req(0, 32'h8, 4'h3, 4'h0, 32'h0);
      txn("pre_rst", 0, 32'h8, 4'h3, 4'h0, 32'h0, 0, 32'h1234_5678, 32'h1234_5678, 1'b0, 2, 1'b0);
      clear_reqs();
      set_req(1, 32'h50, 4'hF, 4'h0, 32'h0);
      r0 = resp_cnt;
      cyc();
      check_val("rst_issue_addr", mem_addr, 32'h50);
      cyc();
      cyc();
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_async_mem", mem_addr | mem_wdata | {24'b0, mem_rmask, mem_wmask}, 32'h0);
      check_val("rst_async_req", req_rdata | {29'b0, req_err, req_resp}, 32'h0);
      cyc();
      cyc();
      check_val("rst_no_resp", 32'(resp_cnt - r0), 32'd0);
      rst_n = 1'b1;
      set_req(0, 32'h60, 4'h0, 4'h1, 32'h6666_6666);
      set_req(1, 32'h70, 4'h0, 4'h2, 32'h7777_7777);
      txn("post_rst", 0, 32'h60, 4'h0, 4'h1, 32'h6666_6666, 0, 32'h0, 32'h0, 1'b0, 2, 1'b0);
      clear_reqs();

      // Spurious mem_resp while IDLE is ignored.
      r0 = resp_cnt;
      p0 = pulse_cnt;
      mem_resp  = 1'b1;
      mem_rdata = 32'h77;
      cyc();
      cyc();
      mem_resp  = 1'b0;
      mem_rdata = 32'h0;
      cyc();
      check_val("spur_no_resp", 32'(resp_cnt - r0), 32'd0);
      check_val("spur_no_pulse", 32'(pulse_cnt - p0), 32'd0);
      set_req(1, 32'h80, 4'hC, 4'h0, 32'h0);
      txn("spur_next", 1, 32'h80, 4'hC, 4'h0, 32'h0, 0, 32'h99, 32'h99, 1'b0, 2, 1'b0);
      clear_reqs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
